cp0_reg: RTL and testbench
==========================

Name: cp0_reg

Overview:
- Coprocessor 0 register file: the consumer of the CP0 write port, read-address port and except-type/current-PC outputs that the EX/MEM stages produce.
- Holds Count, Compare, Status, Cause, EPC, Config and PRId.
- Runs the Count/Compare timer and commits precise exceptions presented by the MEM stage.
- Serves combinational MFC0 reads back to EX.

Parameters:
PRID_VALUE, 32'h004C0102, read-only PRId contents
CONFIG_RESET, 32'h00008000, Config reset value (BE=1, big-endian)
STATUS_RESET, 32'h10000000, Status reset value (CU0=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
we_i  in  1  CP0 write enable (MTC0 at write-back)
waddr_i  in  5  CP0 write register address
data_i  in  32  CP0 write data
raddr_i  in  5  CP0 read address (MFC0 from EX)
int_i  in  6  external hardware interrupt lines
excepttype_i  in  32  encoded exception from MEM: 0x1 int, 0x8 syscall, 0xa RI, 0xc Ov, 0xd Tr, 0xe eret, 0 none
current_pc_i  in  32  PC of the excepting instruction
is_in_delayslot_i  in  1  excepting instruction is in a delay slot
data_o  out  32  read data for raddr_i
count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  register contents
timer_int_o  out  1  timer interrupt request

Behaviour:
- Reset (rst==0 at a clock edge), all outputs registered:
  - count/compare/cause/epc = 0
  - status = STATUS_RESET
  - config = CONFIG_RESET
  - prid = PRID_VALUE
  - timer_int_o = 0
  - Reset mid-operation overrides every other event that cycle.
- Count:
  - Increments by 1 every cycle, wrapping 32'hFFFFFFFF -> 0.
  - An MTC0 to Count (addr 9) loads data_i instead of incrementing.
- Timer:
  - Condition: compare != 0 and count == compare, both evaluated on current registered values.
  - When the condition holds, timer_int_o is set to 1 on the next edge and stays set.
  - An MTC0 to Compare (addr 11) clears timer_int_o and loads compare. A write and a match in the same cycle: the write wins.
- Cause:
  - cause[15:10] <= int_i every cycle.
  - Writable fields via MTC0 (addr 13): IP[9:8], WP[22], IV[23] only. All other bits are read-only.
- MTC0 writes:
  - Status (12) and EPC (14) take the full 32 bits.
  - Config (16) and PRId (15) writes are ignored.
  - Writes to any unlisted address are ignored.
- Exception commit, same edge, evaluated after the MTC0 write so it takes priority on a conflicting field:
  - Codes 0x1/0x8/0xa/0xc/0xd: if status[1] (EXL) == 0, then epc <= is_in_delayslot_i ? current_pc_i-4 : current_pc_i and cause[31] (BD) <= is_in_delayslot_i. If EXL is already 1, EPC and BD are held.
  - In every case: status[1] <= 1 and cause[6:2] <= ExcCode. ExcCode is 0 for int, 8 sys, 10 RI, 12 Ov, 13 Tr.
  - Code 0xe (eret): status[1] <= 0 only.
  - Any other code: no effect.
- Read path:
  - data_o is combinational on raddr_i, from the registered values (addresses 9, 11, 12, 13, 14, 15, 16).
  - Unlisted addresses return 0.
  - No internal write bypass; EX forwards from the MEM/WB CP0 writes itself.
  - During reset, data_o reflects the reset values.
- Latency: one cycle from a write or exception to the visible register value.

Decomposition:
- Add to defines.v:
  - CP0 address constants (CP0_REG_COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14, PRID=15, CONFIG=16).
  - Encoded except-type constants.
  - ExcCode constants.
- No sub-module; a single always block per register group is sufficient.

Test Plan:
- Reset for 2 cycles, then release: status=0x10000000, config=0x00008000, prid=0x004C0102, count=1 one cycle after release, timer_int_o=0.
- MTC0 compare=5, then count=0: timer_int_o rises on the edge after count==5 and stays high. MTC0 compare=20 then clears it the next cycle.
- MTC0 count=0xFFFFFFFE: count reads 0xFFFFFFFF, then 0x0, with no stall.
- excepttype_i=0xc, pc=0x100, delayslot=1, EXL=0: epc=0xFC, cause[31]=1, cause[6:2]=12, status[1]=1. A following excepttype_i=0x8 at pc=0x200 leaves epc=0xFC, sets ExcCode=8.
- excepttype_i=0xe: status[1] cleared, epc unchanged. Simultaneous MTC0 status=0x0000FF03 with excepttype 0x1: status=0x0000FF03, ExcCode=0.
- int_i=6'b100001: cause[15:10]=6'b100001 the next cycle. MTC0 cause=0xFFFFFFFF: only bits 23, 22, 9, 8 change. raddr_i=7: data_o=0.

Source files
------------

// File: rtl/cp0_reg_pkg.sv
// Shared constants for the CP0 register file: register addresses, encoded
// exception types from MEM, and the ExcCode values they commit as.
package cp0_reg_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_TYPE_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_TR      = 32'h0000_000d;
    localparam logic [31:0] EXC_TYPE_ERET    = 32'h0000_000e;

    localparam logic [4:0] EXC_CODE_INT     = 5'd0;
    localparam logic [4:0] EXC_CODE_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_CODE_RI      = 5'd10;
    localparam logic [4:0] EXC_CODE_OV      = 5'd12;
    localparam logic [4:0] EXC_CODE_TR      = 5'd13;

    typedef struct packed {
        logic       commit;
        logic [4:0] code;
    } exc_decode_t;

    // Maps an encoded exception type to whether it commits and its ExcCode.
    function automatic exc_decode_t decode_exc(input logic [31:0] excepttype);
        exc_decode_t d;
        d.commit = 1'b1;
        d.code   = EXC_CODE_INT;
        case (excepttype)
            EXC_TYPE_INT:     d.code = EXC_CODE_INT;
            EXC_TYPE_SYSCALL: d.code = EXC_CODE_SYSCALL;
            EXC_TYPE_RI:      d.code = EXC_CODE_RI;
            EXC_TYPE_OV:      d.code = EXC_CODE_OV;
            EXC_TYPE_TR:      d.code = EXC_CODE_TR;
            default:          d.commit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_reg.sv
// Coprocessor 0 register file: Count/Compare timer, Status/Cause/EPC with
// precise exception commit from MEM, and a combinational MFC0 read port.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
    parameter logic [31:0] CONFIG_RESET = 32'h00008000,
    parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_pc_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    exc_decode_t exc;
    logic        is_eret;
    logic [31:0] exc_epc;

    always_comb begin
        exc     = decode_exc(excepttype_i);
        is_eret = (excepttype_i == EXC_TYPE_ERET);
        exc_epc = is_in_delayslot_i ? (current_pc_i - 32'd4) : current_pc_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_o <= 32'd0;
        end else if (we_i && waddr_i == CP0_REG_COUNT) begin
            count_o <= data_i;
        end else begin
            count_o <= count_o + 32'd1;
        end
    end

    // A Compare write both acknowledges the interrupt and beats a same-cycle match.
    always_ff @(posedge clk) begin
        if (!rst) begin
            compare_o   <= 32'd0;
            timer_int_o <= 1'b0;
        end else if (we_i && waddr_i == CP0_REG_COMPARE) begin
            compare_o   <= data_i;
            timer_int_o <= 1'b0;
        end else if (compare_o != 32'd0 && count_o == compare_o) begin
            timer_int_o <= 1'b1;
        end
    end

    // Exception commit is placed after the MTC0 write so it wins on shared fields.
    always_ff @(posedge clk) begin
        if (!rst) begin
            status_o <= STATUS_RESET;
            cause_o  <= 32'd0;
            epc_o    <= 32'd0;
        end else begin
            cause_o[15:10] <= int_i;
            if (we_i) begin
                case (waddr_i)
                    CP0_REG_STATUS: status_o <= data_i;
                    CP0_REG_CAUSE: begin
                        cause_o[23:22] <= data_i[23:22];
                        cause_o[9:8]   <= data_i[9:8];
                    end
                    CP0_REG_EPC:    epc_o <= data_i;
                    default: ;
                endcase
            end
            if (exc.commit) begin
                if (!status_o[1]) begin
                    epc_o      <= exc_epc;
                    cause_o[31] <= is_in_delayslot_i;
                end
                status_o[1]  <= 1'b1;
                cause_o[6:2] <= exc.code;
            end else if (is_eret) begin
                status_o[1] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            config_o <= CONFIG_RESET;
            prid_o   <= PRID_VALUE;
        end
    end

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            CP0_REG_COUNT:   data_o = count_o;
            CP0_REG_COMPARE: data_o = compare_o;
            CP0_REG_STATUS:  data_o = status_o;
            CP0_REG_CAUSE:   data_o = cause_o;
            CP0_REG_EPC:     data_o = epc_o;
            CP0_REG_PRID:    data_o = prid_o;
            CP0_REG_CONFIG:  data_o = config_o;
            default:         data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed-vector bench for cp0_reg with hand-computed expected register values.
module tb_cp0_reg;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    int checkCount = 0;
    int errorCount = 0;

    cp0_reg dut (
        .clk               (clk),
        .rst               (rst),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .data_i            (data_i),
        .raddr_i           (raddr_i),
        .int_i             (int_i),
        .excepttype_i      (excepttype_i),
        .current_pc_i      (current_pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .data_o            (data_o),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .config_o          (config_o),
        .prid_o            (prid_o),
        .timer_int_o       (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one cycle of write/exception inputs, then returns to idle #1 after the edge.
    task automatic applyStimulus(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                                 input logic [31:0] exc, input logic [31:0] pc, input logic ds);
        we_i              = we;
        waddr_i           = waddr;
        data_i            = wdata;
        excepttype_i      = exc;
        current_pc_i      = pc;
        is_in_delayslot_i = ds;
        @(posedge clk);
        #1;
        we_i              = 1'b0;
        waddr_i           = 5'd0;
        data_i            = 32'd0;
        excepttype_i      = 32'd0;
        current_pc_i      = 32'd0;
        is_in_delayslot_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        raddr_i = 5'd12;
        int_i = 6'd0;
        we_i = 1'b0;
        waddr_i = 5'd0;
        data_i = 32'd0;
        excepttype_i = 32'd0;
        current_pc_i = 32'd0;
        is_in_delayslot_i = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_status", status_o, 32'h10000000);
        checkOutput("rst_config", config_o, 32'h00008000);
        checkOutput("rst_prid", prid_o, 32'h004C0102);
        checkOutput("rst_count", count_o, 32'd0);
        checkOutput("rst_compare", compare_o, 32'd0);
        checkOutput("rst_cause", cause_o, 32'd0);
        checkOutput("rst_epc", epc_o, 32'd0);
        checkOutput("rst_timer", {31'd0, timer_int_o}, 32'd0);
        checkOutput("rst_read_status", data_o, 32'h10000000);

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("count_after_release", count_o, 32'd1);

        // Timer: count=0, compare=5, then count runs up to the match.
        applyStimulus(1, 5'd9, 32'd0, 0, 0, 0);
        checkOutput("count_load0", count_o, 32'd0);
        applyStimulus(1, 5'd11, 32'd5, 0, 0, 0);
        checkOutput("compare_load5", compare_o, 32'd5);
        checkOutput("count_1", count_o, 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("count_5", count_o, 32'd5);
        checkOutput("timer_before_match", {31'd0, timer_int_o}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("timer_rise", {31'd0, timer_int_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("timer_sticky", {31'd0, timer_int_o}, 32'd1);
        applyStimulus(1, 5'd11, 32'd20, 0, 0, 0);
        checkOutput("timer_clear", {31'd0, timer_int_o}, 32'd0);
        checkOutput("compare_load20", compare_o, 32'd20);

        // Count wrap.
        applyStimulus(1, 5'd9, 32'hFFFFFFFE, 0, 0, 0);
        checkOutput("count_fffffffe", count_o, 32'hFFFFFFFE);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("count_ffffffff", count_o, 32'hFFFFFFFF);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("count_wrap0", count_o, 32'd0);

        // Overflow in a delay slot, then syscall while EXL is set, then eret.
        applyStimulus(0, 0, 0, 32'hc, 32'h100, 1);
        checkOutput("ov_epc", epc_o, 32'h000000FC);
        checkOutput("ov_cause", cause_o, 32'h80000030);
        checkOutput("ov_status", status_o, 32'h10000002);
        applyStimulus(0, 0, 0, 32'h8, 32'h200, 0);
        checkOutput("sys_epc_held", epc_o, 32'h000000FC);
        checkOutput("sys_cause", cause_o, 32'h80000020);
        applyStimulus(0, 0, 0, 32'he, 32'h0, 0);
        checkOutput("eret_status", status_o, 32'h10000000);
        checkOutput("eret_epc", epc_o, 32'h000000FC);

        // MTC0 Status together with an interrupt exception.
        applyStimulus(1, 5'd12, 32'h0000FF03, 32'h1, 32'h300, 0);
        checkOutput("int_status", status_o, 32'h0000FF03);
        checkOutput("int_cause", cause_o, 32'h00000000);
        checkOutput("int_epc", epc_o, 32'h00000300);

        // Hardware interrupt lines and masked Cause write.
        int_i = 6'b100001;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("cause_ip_hw", cause_o, 32'h00008400);
        applyStimulus(1, 5'd13, 32'hFFFFFFFF, 0, 0, 0);
        checkOutput("cause_masked_write", cause_o, 32'h00C08700);
        raddr_i = 5'd13;
        #1 checkOutput("read_cause", data_o, 32'h00C08700);
        raddr_i = 5'd7;
        #1 checkOutput("read_unmapped", data_o, 32'd0);
        raddr_i = 5'd15;
        #1 checkOutput("read_prid", data_o, 32'h004C0102);

        // Ignored writes and an unrecognised exception code.
        applyStimulus(1, 5'd16, 32'd0, 0, 0, 0);
        checkOutput("config_ro", config_o, 32'h00008000);
        applyStimulus(1, 5'd15, 32'd0, 0, 0, 0);
        checkOutput("prid_ro", prid_o, 32'h004C0102);
        applyStimulus(1, 5'd20, 32'hDEADBEEF, 32'h5, 32'h400, 1);
        checkOutput("noexc_status", status_o, 32'h0000FF03);
        checkOutput("noexc_epc", epc_o, 32'h00000300);
        checkOutput("noexc_cause", cause_o, 32'h00C08700);

        // Reset mid-operation beats a write and an exception.
        rst = 1'b0;
        applyStimulus(1, 5'd12, 32'hFFFFFFFF, 32'hc, 32'h500, 0);
        checkOutput("midrst_status", status_o, 32'h10000000);
        checkOutput("midrst_epc", epc_o, 32'd0);
        checkOutput("midrst_cause", cause_o, 32'd0);
        checkOutput("midrst_count", count_o, 32'd0);
        checkOutput("midrst_compare", compare_o, 32'd0);
        raddr_i = 5'd16;
        #1 checkOutput("midrst_read_config", data_o, 32'h00008000);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("midrst_count_restart", count_o, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
